// File: rtl/pipe_dist_ram_sdp_if.sv
// ---------------------------------------------------------------------------
// pipe_dist_ram_sdp_if
// Bundles the write port, read request and read response of the
// simple-dual-port distributed RAM.
//   we       [NLANE]   per-lane write enable
//   wr_addr  [ADDR_W]  write address
//   DI       [DATA_W]  write data
//   rd_en              read request
//   rd_addr  [ADDR_W]  read address
//   DO       [DATA_W]  registered read data
//   rd_valid           DO carries a fresh read result this cycle
// master: the block issuing reads/writes.  slave: the RAM itself.
// ---------------------------------------------------------------------------
interface pipe_dist_ram_sdp_if #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 9,
  parameter int LANE_W = 4
);
  localparam int NLANE = DATA_W / LANE_W;

  logic [NLANE-1:0]  we;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] DI;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] DO;
  logic              rd_valid;

  modport master (
    output we, wr_addr, DI, rd_en, rd_addr,
    input  DO, rd_valid
  );

  modport slave (
    input  we, wr_addr, DI, rd_en, rd_addr,
    output DO, rd_valid
  );
endinterface

// File: rtl/pipe_dist_ram_sdp.sv
// ---------------------------------------------------------------------------
// pipe_dist_ram_sdp
// Simple-dual-port distributed RAM with lane-masked writes and a read
// pipeline of PIPE_STAGES registers.  The last pipeline register drives
// DO/rd_valid directly.
//   CLK    rising-edge clock
//   RST_N  asynchronous active-low reset (pipeline only; array is kept)
//   bus    pipe_dist_ram_sdp_if.slave: we/wr_addr/DI write port,
//          rd_en/rd_addr read request, DO/rd_valid read response
// Parameters: DATA_W, ADDR_W (depth 2**ADDR_W), LANE_W (bits per write
// lane), PIPE_STAGES (read latency 1..4), WR_FIRST (collision mode:
// 1 = new lanes are returned, 0 = old contents are returned).
// ---------------------------------------------------------------------------
module pipe_dist_ram_sdp #(
  parameter int DATA_W      = 4,
  parameter int ADDR_W      = 9,
  parameter int LANE_W      = 4,
  parameter int PIPE_STAGES = 2,
  parameter bit WR_FIRST    = 1'b0
) (
  input logic               CLK,
  input logic               RST_N,
  pipe_dist_ram_sdp_if.slave bus
);
  localparam int NLANE = DATA_W / LANE_W;
  localparam int DEPTH = 1 << ADDR_W;

  // Elaboration guards against unsupported configurations.
  if (PIPE_STAGES < 1 || PIPE_STAGES > 4) begin : g_bad_pipe
    $error("pipe_dist_ram_sdp: PIPE_STAGES must lie in 1..4");
  end
  if ((DATA_W % LANE_W) != 0) begin : g_bad_lane
    $error("pipe_dist_ram_sdp: DATA_W must be a multiple of LANE_W");
  end

  logic [DATA_W-1:0]                   mem_r [DEPTH];
  logic [DATA_W-1:0]                   rd_old_s;
  logic [DATA_W-1:0]                   rd_word_s;
  logic [PIPE_STAGES-1:0][DATA_W-1:0]  data_r;
  logic [PIPE_STAGES-1:0]              valid_r;

  // Lane-masked write port. Contents are never cleared; writes are simply
  // ignored while RST_N is low.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      // array contents intentionally preserved across reset
    end else begin
      for (int i = 0; i < NLANE; i++) begin
        if (bus.we[i]) begin
          mem_r[bus.wr_addr][i*LANE_W +: LANE_W] <= bus.DI[i*LANE_W +: LANE_W];
        end
      end
    end
  end

  // Asynchronous array read with optional write-first bypass on an
  // address collision. Lanes not being written always come from the array.
  always_comb begin
    rd_old_s  = mem_r[bus.rd_addr];
    rd_word_s = rd_old_s;
    if (WR_FIRST && (bus.wr_addr == bus.rd_addr)) begin
      for (int i = 0; i < NLANE; i++) begin
        if (bus.we[i]) begin
          rd_word_s[i*LANE_W +: LANE_W] = bus.DI[i*LANE_W +: LANE_W];
        end else begin
          rd_word_s[i*LANE_W +: LANE_W] = rd_old_s[i*LANE_W +: LANE_W];
        end
      end
    end else begin
      rd_word_s = rd_old_s;
    end
  end

  // Read pipeline: valid bits shift every cycle; a data stage only loads
  // behind a valid bit so bubbles leave the data registers untouched and
  // the output holds the last result.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      data_r  <= '0;
      valid_r <= '0;
    end else begin
      valid_r[0] <= bus.rd_en;
      if (bus.rd_en) begin
        data_r[0] <= rd_word_s;
      end
      for (int s = 1; s < PIPE_STAGES; s++) begin
        valid_r[s] <= valid_r[s-1];
        if (valid_r[s-1]) begin
          data_r[s] <= data_r[s-1];
        end
      end
    end
  end

  assign bus.DO       = data_r[PIPE_STAGES-1];
  assign bus.rd_valid = valid_r[PIPE_STAGES-1];

endmodule

// File: tb/tb_pipe_dist_ram_sdp.sv
// ---------------------------------------------------------------------------
// tb_pipe_dist_ram_sdp
// Drives four differently configured RAMs with one shared stimulus stream
// (directed steps followed by random traffic) and compares every output,
// every cycle, against a reference model: a plain array memory plus a
// per-edge record of read results, shown PIPE_STAGES-1 edges later.
//   u0: 4b data, 9b addr, 4b lanes, 2 stages, read-old
//   u1: 16b data, 4b addr, 4b lanes, 1 stage, write-first
//   u2: 16b data, 4b addr, 4b lanes, 4 stages, read-old
//   u3: 8b data, 3b addr, 2b lanes, 3 stages, write-first
// ---------------------------------------------------------------------------
module tb_pipe_dist_ram_sdp;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  we_tb = 4'h0;
  logic [8:0]  wa_tb = 9'h000;
  logic [15:0] di_tb = 16'h0000;
  logic        re_tb = 1'b0;
  logic [8:0]  ra_tb = 9'h000;

  int checks = 0;
  int failures = 0;

  localparam int P_Q  [4] = '{2, 1, 4, 3};
  localparam int DW_Q [4] = '{4, 16, 16, 8};
  localparam int LW_Q [4] = '{4, 4, 4, 2};
  localparam int AW_Q [4] = '{9, 4, 4, 3};
  localparam bit WF_Q [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

  always #5 clk = ~clk;

  pipe_dist_ram_sdp_if #(.DATA_W(4),  .ADDR_W(9), .LANE_W(4)) if0 ();
  pipe_dist_ram_sdp_if #(.DATA_W(16), .ADDR_W(4), .LANE_W(4)) if1 ();
  pipe_dist_ram_sdp_if #(.DATA_W(16), .ADDR_W(4), .LANE_W(4)) if2 ();
  pipe_dist_ram_sdp_if #(.DATA_W(8),  .ADDR_W(3), .LANE_W(2)) if3 ();

  pipe_dist_ram_sdp #(.DATA_W(4), .ADDR_W(9), .LANE_W(4), .PIPE_STAGES(2), .WR_FIRST(1'b0))
    u0 (.CLK(clk), .RST_N(rst_n), .bus(if0));
  pipe_dist_ram_sdp #(.DATA_W(16), .ADDR_W(4), .LANE_W(4), .PIPE_STAGES(1), .WR_FIRST(1'b1))
    u1 (.CLK(clk), .RST_N(rst_n), .bus(if1));
  pipe_dist_ram_sdp #(.DATA_W(16), .ADDR_W(4), .LANE_W(4), .PIPE_STAGES(4), .WR_FIRST(1'b0))
    u2 (.CLK(clk), .RST_N(rst_n), .bus(if2));
  pipe_dist_ram_sdp #(.DATA_W(8), .ADDR_W(3), .LANE_W(2), .PIPE_STAGES(3), .WR_FIRST(1'b1))
    u3 (.CLK(clk), .RST_N(rst_n), .bus(if3));

  assign if0.we = we_tb[0:0];
  assign if0.wr_addr = wa_tb;
  assign if0.DI = di_tb[3:0];
  assign if0.rd_en = re_tb;
  assign if0.rd_addr = ra_tb;
  assign if1.we = we_tb;
  assign if1.wr_addr = wa_tb[3:0];
  assign if1.DI = di_tb;
  assign if1.rd_en = re_tb;
  assign if1.rd_addr = ra_tb[3:0];
  assign if2.we = we_tb;
  assign if2.wr_addr = wa_tb[3:0];
  assign if2.DI = di_tb;
  assign if2.rd_en = re_tb;
  assign if2.rd_addr = ra_tb[3:0];
  assign if3.we = we_tb;
  assign if3.wr_addr = wa_tb[2:0];
  assign if3.DI = di_tb[7:0];
  assign if3.rd_en = re_tb;
  assign if3.rd_addr = ra_tb[2:0];

  logic [15:0] do_w [4];
  logic        vld_w [4];
  assign do_w[0] = {12'h000, if0.DO};
  assign do_w[1] = if1.DO;
  assign do_w[2] = if2.DO;
  assign do_w[3] = {8'h00, if3.DO};
  assign vld_w[0] = if0.rd_valid;
  assign vld_w[1] = if1.rd_valid;
  assign vld_w[2] = if2.rd_valid;
  assign vld_w[3] = if3.rd_valid;

  // Reference model state
  logic [15:0] mm [4][512];
  bit          iv [4][4096];
  logic [15:0] id [4][4096];
  logic [15:0] exp_do [4];
  bit          exp_v [4];
  int          edge_n = 0;
  int          last_rst = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("u%0d_valid@%0d", i, edge_n), {15'h0000, vld_w[i]}, {15'h0000, exp_v[i]});
      chk($sformatf("u%0d_do@%0d", i, edge_n), do_w[i], exp_do[i]);
    end
  endtask

  // One rising edge: advance the model from the current inputs, then check.
  task automatic tick();
    @(posedge clk);
    edge_n++;
    for (int i = 0; i < 4; i++) begin
      int amask;
      int wa;
      int ra;
      int src;
      logic [15:0] word;
      amask = (1 << AW_Q[i]) - 1;
      wa = int'(wa_tb) & amask;
      ra = int'(ra_tb) & amask;
      if (!rst_n) begin
        last_rst = edge_n;
        exp_v[i] = 1'b0;
        exp_do[i] = 16'h0000;
      end else begin
        iv[i][edge_n] = 1'b0;
        if (re_tb) begin
          word = 16'h0000;
          for (int b = 0; b < DW_Q[i]; b++) begin
            word[b] = mm[i][ra][b];
            if (WF_Q[i] && wa == ra && we_tb[b / LW_Q[i]]) word[b] = di_tb[b];
          end
          iv[i][edge_n] = 1'b1;
          id[i][edge_n] = word;
        end
        for (int b = 0; b < DW_Q[i]; b++) begin
          if (we_tb[b / LW_Q[i]]) mm[i][wa][b] = di_tb[b];
        end
        src = edge_n - P_Q[i] + 1;
        exp_v[i] = (src > last_rst) && iv[i][src];
        if (exp_v[i]) exp_do[i] = id[i][src];
      end
    end
    #1;
    check_all();
  endtask

  task automatic step(input logic [3:0] we, input logic [8:0] wa, input logic [15:0] di,
                      input logic re, input logic [8:0] ra);
    @(negedge clk);
    we_tb = we;
    wa_tb = wa;
    di_tb = di;
    re_tb = re;
    ra_tb = ra;
    tick();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(4'h0, 9'h000, 16'h0000, 1'b0, 9'h000);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      exp_do[i] = 16'h0000;
      exp_v[i] = 1'b0;
    end
    #2 rst_n = 1'b0;
    tick();
    tick();
    chk("rst_do_u2", do_w[2], 16'h0000);
    chk("rst_valid_u2", {15'h0000, vld_w[2]}, 16'h0000);
    @(negedge clk) rst_n = 1'b1;

    // Fill every address; DI carries the address nibble in each lane.
    for (int a = 0; a < 512; a++) begin
      logic [8:0] av;
      av = 9'(a);
      step(4'hF, av, {4{av[3:0]}}, 1'b0, 9'h000);
    end
    // Back-to-back reads of every address.
    for (int a = 0; a < 512; a++) step(4'h0, 9'h000, 16'h0000, 1'b1, 9'(a));
    idle(4);

    // Lane masking.
    step(4'hF, 9'h005, 16'hABCD, 1'b0, 9'h000);
    step(4'b0101, 9'h005, 16'h1234, 1'b0, 9'h000);
    step(4'h0, 9'h000, 16'h0000, 1'b1, 9'h005);
    chk("lane_mask_u1", do_w[1], 16'hA2C4);
    idle(4);

    // Read/write collision on address 7.
    step(4'hF, 9'h007, 16'h0003, 1'b0, 9'h000);
    step(4'hF, 9'h007, 16'h0009, 1'b1, 9'h007);
    chk("coll_wf1_u1", do_w[1], 16'h0009);
    step(4'h0, 9'h000, 16'h0000, 1'b1, 9'h007);
    chk("coll_next_u1", do_w[1], 16'h0009);
    chk("coll_wf0_u0", do_w[0], 16'h0003);
    idle(1);
    chk("coll_next_u0", do_w[0], 16'h0009);
    idle(4);

    // Single request: one pulse per instance at its own latency.
    step(4'h0, 9'h000, 16'h0000, 1'b1, 9'h009);
    idle(5);

    // Reset while reads are in flight.
    step(4'hF, 9'h002, 16'h0006, 1'b0, 9'h000);
    step(4'h0, 9'h000, 16'h0000, 1'b1, 9'h002);
    step(4'h0, 9'h000, 16'h0000, 1'b1, 9'h002);
    @(negedge clk);
    we_tb = 4'h0;
    re_tb = 1'b0;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      exp_do[i] = 16'h0000;
      exp_v[i] = 1'b0;
    end
    last_rst = edge_n;
    check_all();
    tick();
    @(negedge clk) rst_n = 1'b1;
    idle(5);
    step(4'h0, 9'h000, 16'h0000, 1'b1, 9'h002);
    chk("post_rst_u1", do_w[1], 16'h0006);
    idle(1);
    chk("post_rst_u0", do_w[0], 16'h0006);
    idle(4);

    // Bubble pattern 1,0,1,1,0.
    step(4'h0, 9'h000, 16'h0000, 1'b1, 9'h001);
    step(4'h0, 9'h000, 16'h0000, 1'b0, 9'h000);
    step(4'h0, 9'h000, 16'h0000, 1'b1, 9'h002);
    step(4'h0, 9'h000, 16'h0000, 1'b1, 9'h003);
    step(4'h0, 9'h000, 16'h0000, 1'b0, 9'h000);
    idle(5);

    // Random concurrent traffic on a small address window.
    repeat (300) begin
      step(4'($urandom_range(0, 15)), 9'($urandom_range(0, 15)), 16'($urandom),
           1'($urandom_range(0, 1)), 9'($urandom_range(0, 15)));
    end
    idle(6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipe_dist_ram_sdp.md
Name: pipe_dist_ram_sdp

Overview:
- Parametrised simple-dual-port distributed RAM: one write port and one independent read port on a single clock.
- Read pipeline depth is configurable; a valid strobe travels with each read.
- Write enables are per lane; read-during-write collision behaviour is selectable.
- Successor to the single-port pipelined distributed RAM; used as a register-file and lookup store in datapath blocks.

Parameters:
- DATA_W, 4: word width in bits; must be a multiple of LANE_W.
- ADDR_W, 9: address width; depth = 2**ADDR_W words.
- LANE_W, 4: bits per write-enable lane; NLANE = DATA_W/LANE_W.
- PIPE_STAGES, 2: read latency in cycles, legal range 1..4.
- WR_FIRST, 0: collision mode. 1 = read returns newly written lanes; 0 = read returns old contents.

Ports:
- CLK  input  1  rising-edge clock.
- RST_N  input  1  asynchronous active-low reset.
- we  input  NLANE  per-lane write enable.
- wr_addr  input  ADDR_W  write address.
- DI  input  DATA_W  write data.
- rd_en  input  1  read request.
- rd_addr  input  ADDR_W  read address.
- DO  output  DATA_W  read data, registered.
- rd_valid  output  1  DO carries the result of a read issued PIPE_STAGES cycles earlier.

Behaviour:
- Memory array is not reset. Contents are undefined until written and are preserved across reset.
- Reset (RST_N low, asynchronous): DO=0, rd_valid=0, all internal pipeline data and valid bits = 0.
- While RST_N is low, writes are ignored. First legal write is the first rising edge with RST_N high.
- Write: at each rising edge, for every lane i with we[i]=1, RAM[wr_addr] bits [i*LANE_W +: LANE_W] take DI in the same lanes. Lanes with we[i]=0 keep their value.
- Read stage 1: at a rising edge with rd_en=1, stage-1 data captures RAM[rd_addr] and valid_1=1. With rd_en=0, valid_1=0 and stage-1 data holds its value.
- Stages 2..PIPE_STAGES: valid bits shift every cycle. A data stage loads only when the preceding valid bit is 1, so there is no toggling on bubbles.
- Output: the final stage drives DO/rd_valid directly from registers. rd_valid pulses for exactly one cycle per request.
- DO holds its last valid value while rd_valid=0.
- Latency: request sampled at edge k gives DO/rd_valid updated at edge k+PIPE_STAGES-1 after that sample.
  - PIPE_STAGES=1: visible one cycle after the request edge.
  - PIPE_STAGES=2: visible two cycles after.
- Throughput: one read per cycle, back-to-back, no stalls. Reads and writes are fully concurrent.
- Collision (same edge, rd_en=1, rd_addr==wr_addr, any we bit set):
  - WR_FIRST=1: the captured word takes DI in enabled lanes and old RAM data in the others.
  - WR_FIRST=0: the captured word is entirely old RAM contents.
  - Collision affects only that read. A read one cycle later always sees the new data.
- Address wrap: addresses are modular. Out-of-range cannot occur because depth = 2**ADDR_W.
- Reset mid-operation: all in-flight reads are discarded (rd_valid stays 0 and no late pulse after release). Stored contents are unchanged.
- Illegal parameter values (PIPE_STAGES outside 1..4, DATA_W % LANE_W != 0) stop elaboration via a generate-time error.

Test Plan:
- Write/read with defaults: we=1, addr 0x000..0x1FF, DI=addr[3:0]; then issue reads back-to-back -> rd_valid continuous for 512 cycles starting 2 cycles after the first rd_en; DO sequence 0,1,..,F repeating.
- Lane masking, DATA_W=16 and LANE_W=4: write 0xABCD to addr 5, then write DI=0x1234 with we=4'b0101 -> a read of addr 5 returns 0xA2C4.
- Collision, WR_FIRST=0 vs 1: RAM[7]=0x3; same edge write 0x9 and read addr 7 -> DO=0x3 (mode 0) or 0x9 (mode 1); the next read of addr 7 returns 0x9 in both modes.
- Latency sweep, PIPE_STAGES=1..4: a single rd_en pulse -> exactly one rd_valid pulse, delayed 1..4 cycles after the request edge; DO stable when rd_valid=0.
- Reset mid-flight: write RAM[2]=0x6, issue reads, assert RST_N low for 1 cycle between request and output -> DO=0 and rd_valid=0 asynchronously, no rd_valid pulse afterwards; after release, a read of addr 2 returns 0x6.
- Bubble pattern: rd_en = 1,0,1,1,0 with addresses 1,x,2,3,x -> rd_valid = 1,0,1,1,0 delayed by PIPE_STAGES; DO holds RAM[1] through the bubble.
